// File: rtl/contador_sincrono_crescente_4bits.sv
// 4-bit synchronous up counter (modulo 16) built as a chain of four
// T flip-flop stages sharing one clock. Stage i toggles when the count
// enable is high and every lower stage is already 1, so all carries
// resolve within a single edge. A synchronous clear overrides counting.
module contador_sincrono_crescente_4bits (
  input  logic       clk,
  input  logic       T,
  input  logic       clear,
  output logic [3:0] q
);

  // Per-stage toggle enables.
  // Each stage is enabled by the global enable ANDed with all lower bits.
  // Each enable is written out explicitly so no bit depends on another
  // bit of the same vector.
  logic [3:0] tgl;

  assign tgl[0] = T;
  assign tgl[1] = T & q[0];
  assign tgl[2] = T & (&q[1:0]);
  assign tgl[3] = T & (&q[2:0]);

  // T flip-flop bank.
  // Clear takes priority over toggling. Otherwise each bit flips when its
  // enable is set and holds when it is not.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 4'b0000;
    end else begin
      q <= q ^ tgl;
    end
  end

endmodule

// File: tb/tb_contador_sincrono_crescente_4bits.sv
// Bench for contador_sincrono_crescente_4bits: scoreboard of expected counts,
// inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_contador_sincrono_crescente_4bits;

  logic       clk = 1'b0;
  logic       T;
  logic       clear;
  logic [3:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mdl;
  logic [3:0] exp_q[$];
  string      tag_q[$];

  contador_sincrono_crescente_4bits dut (
    .clk   (clk),
    .T     (T),
    .clear (clear),
    .q     (q)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%0d (%b) expected %0d (%b) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, push the expected result, then pop and compare
  // after the edge. Returns at the following falling edge.
  task automatic step(input logic c, input logic t, input string tag);
    logic [3:0] e;
    string      tg;
    clear = c;
    T     = t;
    if (c)      mdl = 4'd0;
    else if (t) mdl = mdl + 4'd1;
    exp_q.push_back(mdl);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    chk(tg, q, e);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] prev;
    mdl   = 4'd0;
    clear = 1'b1;
    T     = 1'b1;

    // Reset from unknown state, clear and T both high.
    step(1'b1, 1'b1, "reset");

    // Full count and wrap: 1..15 then 0.
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, $sformatf("count%0d", i));

    // Hold at 5 for three edges, then resume to 6.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "to5");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $sformatf("hold%0d", i));
    step(1'b0, 1'b1, "resume6");

    // Count to 9, then clear with T high: clear must win.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "to9");
    step(1'b1, 1'b1, "clear_prio");
    step(1'b0, 1'b1, "after_clear");

    // Carry chain 7 -> 8, all four bits change in one edge.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "to7");
    prev = q;
    step(1'b0, 1'b1, "carry7to8");
    chk("carry_all_bits", prev ^ q, 4'b1111);

    // Carry chain 15 -> 0.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "to15");
    prev = q;
    step(1'b0, 1'b1, "wrap15to0");
    chk("wrap_all_bits", prev ^ q, 4'b1111);

    // Move off zero so a stray clear would be visible.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "to3");

    // Clear pulse between edges must not disturb q.
    T     = 1'b0;
    clear = 1'b0;
    #2 clear = 1'b1;
    #3;
    chk("async_pulse_during", q, mdl);
    clear = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, "async_pulse_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
